seg7_capture: RTL and testbench

Sequential seven-segment-to-BCD capture block: the receiving end of the BCD-to-7-segment display path. It samples a multiplexed segment bus together with its digit strobes, waits for each strobe/pattern pair to settle, and decodes the pattern back to BCD. It assembles complete multi-digit frames with per-digit error flags. It is used for self-test of the dual-slope ADC display output and for board-level readback of any multiplexed display driven in the same format.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_bcd.sv | 32 +++
 rtl/seg7_capture.sv | 125 ++++++++++++
 tb/tb_seg7_capture.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the display encode and capture paths.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h06;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;
    localparam logic [6:0] SEG_PAT_4 = 7'h66;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;
    localparam logic [6:0] SEG_PAT_7 = 7'h07;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h6F;

    localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational exact-match decode of an active-high segment pattern to BCD.
// Anything outside the ten digit glyphs maps to BCD_INVALID with the flag set.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] bcd_o,
    output logic       invalid_o
);

    always_comb begin
        bcd_o     = BCD_INVALID;
        invalid_o = 1'b0;
        case (pat_i)
            SEG_PAT_0: bcd_o = 4'd0;
            SEG_PAT_1: bcd_o = 4'd1;
            SEG_PAT_2: bcd_o = 4'd2;
            SEG_PAT_3: bcd_o = 4'd3;
            SEG_PAT_4: bcd_o = 4'd4;
            SEG_PAT_5: bcd_o = 4'd5;
            SEG_PAT_6: bcd_o = 4'd6;
            SEG_PAT_7: bcd_o = 4'd7;
            SEG_PAT_8: bcd_o = 4'd8;
            SEG_PAT_9: bcd_o = 4'd9;
            default: begin
                bcd_o     = BCD_INVALID;
                invalid_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed seven-segment bus, waits for each strobe/pattern pair
// to settle, decodes it and assembles complete multi-digit frames.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int COMMON_CATHODE = 1,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      frame_valid,
    output logic                      frame_err
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [6:0]              seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   en_q, en_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    logic                    captured_q, captured_d;
    logic [NUM_DIGITS-1:0]   seen_mask_q, seen_mask_d;
    logic [4*NUM_DIGITS-1:0] stage_bcd_q, stage_bcd_d;
    logic [NUM_DIGITS-1:0]   stage_err_q, stage_err_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    fv_q, fv_d;
    logic                    ferr_q, ferr_d;

    logic [6:0] seg_norm;
    logic [3:0] dec_bcd;
    logic       dec_invalid;
    logic       hold;
    logic       capture;

    assign seg_norm = (COMMON_CATHODE != 0) ? seg_q : ~seg_q;

    seg7_to_bcd u_dec (
        .pat_i     (seg_norm),
        .bcd_o     (dec_bcd),
        .invalid_o (dec_invalid)
    );

    // A sample counts toward settling only if it is one-hot and matches the
    // previous cycle; the capture edge needs STABLE_CYCLES such samples.
    assign hold    = $onehot(en_q) && (seg_q == seg_prev_q) && (en_q == en_prev_q);
    assign capture = hold && (cnt_q == CNT_MAX - 8'd1) && !captured_q;

    always_comb begin
        cnt_d       = 8'd0;
        captured_d  = 1'b0;
        seen_mask_d = seen_mask_q;
        stage_bcd_d = stage_bcd_q;
        stage_err_d = stage_err_q;
        bcd_d       = bcd_q;
        err_d       = err_q;
        ferr_d      = ferr_q;
        fv_d        = 1'b0;

        if (hold) begin
            cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
            captured_d = captured_q | capture;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && en_q[i]) begin
                stage_bcd_d[4*i +: 4] = dec_bcd;
                stage_err_d[i]        = dec_invalid;
                seen_mask_d[i]        = 1'b1;
            end
        end

        // frame_valid is a one-cycle strobe with no ready; bcd, digit_err and
        // frame_err stay stable from that cycle until the next strobe.
        if (capture && (seen_mask_d == '1)) begin
            bcd_d       = stage_bcd_d;
            err_d       = stage_err_d;
            ferr_d      = |stage_err_d;
            fv_d        = 1'b1;
            seen_mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= '0;
            seg_prev_q  <= '0;
            en_q        <= '0;
            en_prev_q   <= '0;
            cnt_q       <= '0;
            captured_q  <= 1'b0;
            seen_mask_q <= '0;
            stage_bcd_q <= '0;
            stage_err_q <= '0;
            bcd_q       <= '0;
            err_q       <= '0;
            fv_q        <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            seg_q       <= seg;
            seg_prev_q  <= seg_q;
            en_q        <= dig_en;
            en_prev_q   <= en_q;
            cnt_q       <= cnt_d;
            captured_q  <= captured_d;
            seen_mask_q <= seen_mask_d;
            stage_bcd_q <= stage_bcd_d;
            stage_err_q <= stage_err_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            fv_q        <= fv_d;
            ferr_q      <= ferr_d;
        end
    end

    assign bcd         = bcd_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a common-cathode and a common-anode
// instance see the same logical stimulus; each has its own frame scoreboard.
module tb_seg7_capture;

    localparam int N = 4;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   seg;
    logic [6:0]   seg_n;
    logic [N-1:0] dig_en;

    logic [4*N-1:0] bcd_p, bcd_n;
    logic [N-1:0]   err_p, err_n;
    logic           fv_p, fv_n, ferr_p, ferr_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] exp_q_p[$];
    logic [20:0] exp_q_n[$];

    assign seg_n = ~seg;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seg7_capture #(.NUM_DIGITS(N), .COMMON_CATHODE(1), .STABLE_CYCLES(S)) dut_p (
        .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
        .bcd(bcd_p), .digit_err(err_p), .frame_valid(fv_p), .frame_err(ferr_p)
    );

    seg7_capture #(.NUM_DIGITS(N), .COMMON_CATHODE(0), .STABLE_CYCLES(S)) dut_n (
        .clk(clk), .rst(rst), .seg(seg_n), .dig_en(dig_en),
        .bcd(bcd_n), .digit_err(err_n), .frame_valid(fv_n), .frame_err(ferr_n)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_frame(input string tag, input logic [20:0] e,
                             input logic [15:0] b, input logic [3:0] de, input logic fe);
        check({tag, "_bcd"}, {16'd0, b}, {16'd0, e[20:5]});
        check({tag, "_digit_err"}, {28'd0, de}, {28'd0, e[4:1]});
        check({tag, "_frame_err"}, {31'd0, fe}, {31'd0, e[0]});
    endtask

    // ---------------- monitors ----------------
    logic fv_prev_p = 1'b0;
    logic fv_prev_n = 1'b0;

    always @(negedge clk) begin
        if (fv_p) begin
            check("fv_p_not_back_to_back", {31'd0, fv_prev_p}, 32'd0);
            if (exp_q_p.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_p_unexpected: got bcd %h err %b, expected no frame", bcd_p, err_p);
            end else begin
                cmp_frame("frame_p", exp_q_p.pop_front(), bcd_p, err_p, ferr_p);
            end
        end
        fv_prev_p = fv_p;
    end

    always @(negedge clk) begin
        if (fv_n) begin
            check("fv_n_not_back_to_back", {31'd0, fv_prev_n}, 32'd0);
            if (exp_q_n.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_n_unexpected: got bcd %h err %b, expected no frame", bcd_n, err_n);
            end else begin
                cmp_frame("frame_n", exp_q_n.pop_front(), bcd_n, err_n, ferr_n);
            end
        end
        fv_prev_n = fv_n;
    end

    // ---------------- drivers ----------------
    task automatic hold(input logic [N-1:0] en, input logic [6:0] pat, input int cycles);
        dig_en = en;
        seg    = pat;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3, input int cycles);
        hold(4'b0001, p0, cycles);
        hold(4'b0010, p1, cycles);
        hold(4'b0100, p2, cycles);
        hold(4'b1000, p3, cycles);
        hold(4'b0000, 7'h00, 3);
    endtask

    task automatic expect_frame(input logic [15:0] b, input logic [3:0] de);
        exp_q_p.push_back({b, de, |de});
        exp_q_n.push_back({b, de, |de});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bcd_p"}, {16'd0, bcd_p}, 32'd0);
        check({tag, "_err_p"}, {28'd0, err_p}, 32'd0);
        check({tag, "_fv_p"}, {31'd0, fv_p}, 32'd0);
        check({tag, "_ferr_p"}, {31'd0, ferr_p}, 32'd0);
        check({tag, "_bcd_n"}, {16'd0, bcd_n}, 32'd0);
        check({tag, "_ferr_n"}, {31'd0, ferr_n}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        seg    = 7'h00;
        dig_en = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_outputs_zero("reset");
        rst = 1'b0;
        hold(4'b0000, 7'h00, 2);

        // basic scan 1,2,3,4
        expect_frame(16'h4321, 4'b0000);
        scan(7'h06, 7'h5B, 7'h4F, 7'h66, 8);

        // invalid glyph on digit 2
        expect_frame(16'h0F59, 4'b0100);
        scan(7'h6F, 7'h6D, 7'h7E, 7'h3F, 8);

        // 4-cycle dwell on digit 0 must not be captured
        hold(4'b0001, 7'h07, 4);
        hold(4'b0000, 7'h00, 2);
        expect_frame(16'h4321, 4'b0000);
        hold(4'b0010, 7'h5B, 8);
        hold(4'b0100, 7'h4F, 8);
        hold(4'b1000, 7'h66, 8);
        hold(4'b0001, 7'h06, 8);
        hold(4'b0000, 7'h00, 3);

        // minimum capturable dwell of STABLE_CYCLES+1
        expect_frame(16'h9876, 4'b0000);
        scan(7'h7D, 7'h07, 7'h7F, 7'h6F, S + 1);

        // one-cycle glitch restarts settling: 4 + glitch + 4 is not captured
        hold(4'b0001, 7'h06, 4);
        hold(4'b0001, 7'h00, 1);
        hold(4'b0001, 7'h06, 4);
        hold(4'b0000, 7'h00, 2);
        expect_frame(16'h7539, 4'b0000);
        hold(4'b0010, 7'h4F, 8);
        hold(4'b0100, 7'h6D, 8);
        hold(4'b1000, 7'h07, 8);
        hold(4'b0001, 7'h6F, 8);
        hold(4'b0000, 7'h00, 3);

        // multi-hot and blank strobes are never qualified
        hold(4'b0011, 7'h06, 20);
        hold(4'b0000, 7'h06, 20);
        check("seen_mask_p_after_unqualified", {28'd0, dut_p.seen_mask_q}, 32'd0);
        check("seen_mask_n_after_unqualified", {28'd0, dut_n.seen_mask_q}, 32'd0);

        // reset mid-frame discards the partial frame
        hold(4'b0001, 7'h7F, 8);
        hold(4'b0010, 7'h7F, 8);
        check("seen_mask_p_partial", {28'd0, dut_p.seen_mask_q}, 32'd3);
        rst = 1'b1;
        hold(4'b0000, 7'h00, 2);
        check_outputs_zero("mid_reset");
        check("seen_mask_p_in_reset", {28'd0, dut_p.seen_mask_q}, 32'd0);
        rst = 1'b0;
        expect_frame(16'h7560, 4'b0000);
        hold(4'b0100, 7'h6D, 8);
        hold(4'b1000, 7'h07, 8);
        hold(4'b0001, 7'h3F, 8);
        hold(4'b0010, 7'h7D, 8);
        hold(4'b0000, 7'h00, 3);

        // all-eights frame; the active-low instance sees ~0x7F on its pins
        expect_frame(16'h8888, 4'b0000);
        scan(7'h7F, 7'h7F, 7'h7F, 7'h7F, 8);

        hold(4'b0000, 7'h00, 5);
        check("queue_p_drained", exp_q_p.size(), 32'd0);
        check("queue_n_drained", exp_q_n.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
